axi_wr_arbiter: RTL

Two-requester round-robin arbiter that shares the single AXI write path (AW, W, B channels) of the protocol FSM between two upstream masters. It sequences one complete write transaction at a time: address, all data beats, then the write response. Only then is the path released and re-arbitrated. It sits between the two traffic sources and the `awaddr_in`/`wdata_in`/`bready_in` side of the AXI write FSM.

---
 rtl/axi_wr_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: two-requester round-robin owner of one AXI write path.
// A full AW/W/B transaction completes before the path is re-arbitrated.
module axi_wr_arbiter #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic                axi_aclk,
  input  logic                rst_n,
  input  logic [2*AW-1:0]     s_awaddr,
  input  logic [15:0]         s_awlen,
  input  logic [5:0]          s_awsize,
  input  logic [3:0]          s_awburst,
  input  logic [1:0]          s_awvalid,
  output logic [1:0]          s_awready,
  input  logic [2*DW-1:0]     s_wdata,
  input  logic [2*(DW/8)-1:0] s_wstrb,
  input  logic [1:0]          s_wlast,
  input  logic [1:0]          s_wvalid,
  output logic [1:0]          s_wready,
  output logic [3:0]          s_bresp,
  output logic [1:0]          s_bvalid,
  input  logic [1:0]          s_bready,
  output logic [AW-1:0]       m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DW-1:0]       m_wdata,
  output logic [DW/8-1:0]     m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic                grant,
  output logic                busy,
  output logic                wlast_err
);

  typedef enum logic [1:0] {
    IDLE, ADDR, DATA, RESP
  } state_t;

  state_t     state;
  logic       last;
  logic [7:0] cnt;
  logic [7:0] beats;
  logic       win;
  logic       in_addr;
  logic       in_data;
  logic       in_resp;
  logic       final_beat;
  logic [1:0] sel;

  assign in_addr    = state == ADDR;
  assign in_data    = state == DATA;
  assign in_resp    = state == RESP;
  assign sel        = {grant, ~grant};
  assign final_beat = cnt == beats;
  assign busy       = state != IDLE;

  // On a tie the requester that did not finish last wins.
  assign win = (&s_awvalid) ? ~last : s_awvalid[1];

  always_comb begin
    m_awaddr  = '0;
    m_awlen   = '0;
    m_awsize  = '0;
    m_awburst = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    if (in_addr) begin
      m_awaddr  = grant ? s_awaddr[AW +: AW] : s_awaddr[0 +: AW];
      m_awlen   = grant ? s_awlen[15:8]  : s_awlen[7:0];
      m_awsize  = grant ? s_awsize[5:3]  : s_awsize[2:0];
      m_awburst = grant ? s_awburst[3:2] : s_awburst[1:0];
    end
    if (in_data) begin
      m_wdata = grant ? s_wdata[DW +: DW] : s_wdata[0 +: DW];
      m_wstrb = grant ? s_wstrb[DW/8 +: DW/8]
                      : s_wstrb[0 +: DW/8];
    end
  end

  assign m_awvalid = in_addr & s_awvalid[grant];
  assign m_wvalid  = in_data & s_wvalid[grant];
  assign m_wlast   = in_data & final_beat;
  assign m_bready  = in_resp & s_bready[grant];

  assign s_awready = sel & {2{in_addr & m_awready}};
  assign s_wready  = sel & {2{in_data & m_wready}};
  assign s_bvalid  = sel & {2{in_resp & m_bvalid}};
  assign s_bresp   = in_resp ? {2{m_bresp}} : 4'b0;

  always_ff @(posedge axi_aclk) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= 1'b0;
      last      <= 1'b1;
      cnt       <= '0;
      beats     <= '0;
      wlast_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|s_awvalid) begin
            grant <= win;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (m_awvalid && m_awready) begin
            beats <= m_awlen;
            cnt   <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (m_wvalid && m_wready) begin
            if (s_wlast[grant] != final_beat)
              wlast_err <= 1'b1;
            // Hold cnt on the final beat so awlen=255 never wraps.
            if (final_beat)
              state <= RESP;
            else
              cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          if (m_bvalid && m_bready) begin
            last  <= grant;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
